i2c_bus_arbiter: RTL and testbench
==================================

# i2c_bus_arbiter

Round-robin arbiter that shares one `i2c_master` instance among up to eight configuration requesters, for example the HDMI transmitter init sequencer and the camera init sequencers. It sits between the requesters and the master's register-transaction port. It serializes single-register read and write transactions and returns completion, status and read data to the owning requester. A watchdog frees the bus if the master never reports done.

## Interface
- `N_REQ`, 2: number of requesters; legal range 1..8.
- `TIMEOUT_CYCLES`, 1_000_000: clk cycles allowed in WAIT before abort; 0 disables the watchdog.
- `clk` in 1: system clock.
- `reset` in 1: reset, asynchronous, active-low.
- `req` in N_REQ: level request per requester; held until its `ack`.
- `req_rnw` in N_REQ: 1 = read, 0 = write.
- `req_chip_addr` in 7*N_REQ: 7-bit device address; requester i uses bits [7i+6:7i].
- `req_reg_addr` in 8*N_REQ: register address, 8 bits per requester.
- `req_wdata` in 8*N_REQ: write data, 8 bits per requester; ignored for reads.
- `grant` out N_REQ: one-hot owner; high from grant through the ack cycle inclusive.
- `ack` out N_REQ: one-cycle completion pulse to the owner.
- `rdata` out 8: read data; valid in the ack cycle and held until the next ack.
- `status` out 3: master status, or 3'b111 on timeout; valid in the ack cycle and held.
- `m_chip_addr` out 7: to the master's `chip_addr`.
- `m_reg_addr` out 8: to the master's `reg_addr`.
- `m_data_in` out 8: to the master's `data_in`.
- `m_write_en` out 1: one-cycle write start pulse.
- `m_read_en` out 1: one-cycle read start pulse.
- `m_done` in 1: master completion.
- `m_busy` in 1: master busy.
- `m_status` in 3: master status.
- `m_data_out` in 8: master read data.

## Operation
- FSM states:
  - IDLE:
    - Stays in IDLE while no `req` bit is set or `m_busy`=1.
    - Otherwise it selects the first set `req` bit searching upward from `ptr` with wrap-around, sets `grant` one-hot and goes to ISSUE.
  - ISSUE (1 cycle):
    - Latches the owner's chip_addr, reg_addr and wdata into the `m_*` registers.
    - Pulses `m_read_en` if `req_rnw` is set, else `m_write_en`.
    - Clears the watchdog counter and goes to WAIT.
  - WAIT:
    - `m_done` is ignored in the first WAIT cycle, to avoid a stale done level.
    - From the second cycle, `m_done`=1 captures `m_status` into `status` and `m_data_out` into `rdata`, then goes to ACK.
    - If the counter reaches `TIMEOUT_CYCLES`, it sets `status`=3'b111, leaves `rdata` unchanged and goes to ACK.
  - ACK (1 cycle):
    - `ack[owner]`=1 and `ptr` is set to (owner+1) mod N_REQ.
    - Next cycle: `grant` returns to 0 and the FSM returns to IDLE.
- Requester rules:
  - Fields must be stable from `req` rise through `ack`.
  - Dropping `req` before grant withdraws the request with no side effects.
  - Dropping `req` after grant does not abort the transaction; `ack` is still issued.
  - After `ack`, a requester still holding `req` re-enters arbitration at lowest priority.
- `ptr` is $clog2(N_REQ) bits wide, minimum 1. Wrap-around is done by compare-and-clear, not by power-of-two masking.
- The watchdog counter is 32 bits wide and saturates.
- `m_write_en` and `m_read_en` are never high simultaneously and never high outside ISSUE.

## Timing
- Reset values:
  - state=IDLE, ptr=0.
  - `grant`=0, `ack`=0, `rdata`=0, `status`=0.
  - `m_chip_addr`, `m_reg_addr`, `m_data_in`=0.
  - `m_write_en`=0, `m_read_en`=0.
- Reset mid-transaction:
  - Immediately forces all of the above; no `ack` is issued for the aborted transaction.
  - The master is reset by the same signal.
- Latency:
  - From `req` high in IDLE (`m_busy`=0) to `grant`: 1 cycle.
  - From `grant` to the start pulse: 1 cycle.
  - From `m_done` seen in WAIT to `ack`: 1 cycle.
- The minimum gap between back-to-back transactions is 2 idle cycles (ACK, then IDLE).
- Simultaneous requests are resolved purely by `ptr`. No requester waits more than N_REQ-1 transactions.
- A `req` rise in the same cycle as another owner's `ack` is considered in the next IDLE.

## Test plan
- Single write, N_REQ=2:
  - Stimulus: req[0] with chip 7'h39, reg 8'h41, data 8'h00.
  - Required: grant=2'b01 one cycle later; one m_write_en pulse with those values; ack[0] one cycle after m_done; status = m_status.
- Contention:
  - Stimulus: req=2'b11 held continuously.
  - Required: service order 0,1,0,1; each ack is followed by grant to the other requester; never two grants at once.
- Read:
  - Stimulus: req[1] read of reg 8'h42; the model returns 8'h5A.
  - Required: m_read_en pulse; rdata=8'h5A in the ack[1] cycle, held afterward.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=100; the model never asserts m_done.
  - Required: ack about 100 cycles after issue with status=3'b111; the next request is then granted.
- Reset mid-WAIT:
  - Stimulus: assert reset during WAIT.
  - Required: all outputs 0 in the same cycle; no ack; after release, a pending req is granted starting from ptr=0.
- Stale done and busy:
  - Stimulus: m_done held high through ISSUE; m_busy=1 in IDLE.
  - Required: the first WAIT cycle is ignored; no grant is issued until m_busy=0.

Source files
------------

// File: rtl/i2c_bus_arbiter_if.sv
// i2c_bus_arbiter_if: requester-side and i2c_master-side transaction signals around the arbiter
interface i2c_bus_arbiter_if #(parameter int N_REQ = 2);
  logic [N_REQ-1:0]   req;
  logic [N_REQ-1:0]   req_rnw;
  logic [7*N_REQ-1:0] req_chip_addr;
  logic [8*N_REQ-1:0] req_reg_addr;
  logic [8*N_REQ-1:0] req_wdata;
  logic [N_REQ-1:0]   grant;
  logic [N_REQ-1:0]   ack;
  logic [7:0]         rdata;
  logic [2:0]         status;
  logic [6:0]         m_chip_addr;
  logic [7:0]         m_reg_addr;
  logic [7:0]         m_data_in;
  logic               m_write_en;
  logic               m_read_en;
  logic               m_done;
  logic               m_busy;
  logic [2:0]         m_status;
  logic [7:0]         m_data_out;
  modport slave (
    input  req, req_rnw, req_chip_addr, req_reg_addr, req_wdata,
    input  m_done, m_busy, m_status, m_data_out,
    output grant, ack, rdata, status,
    output m_chip_addr, m_reg_addr, m_data_in, m_write_en, m_read_en
  );
  modport master (
    output req, req_rnw, req_chip_addr, req_reg_addr, req_wdata,
    output m_done, m_busy, m_status, m_data_out,
    input  grant, ack, rdata, status,
    input  m_chip_addr, m_reg_addr, m_data_in, m_write_en, m_read_en
  );
endinterface

// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter: round-robin sharing of one i2c_master among up to eight register requesters
module i2c_bus_arbiter #(
  parameter int          N_REQ          = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input logic              clk,
  input logic              reset,
  i2c_bus_arbiter_if.slave bus
);
  localparam int PW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d, owner_q, owner_d, sel, jj;
  logic [N_REQ-1:0] grant_q, grant_d, ack_q, ack_d, sel_oh;
  logic [7:0]       rdata_q, rdata_d, m_reg_q, m_reg_d, m_data_q, m_data_d;
  logic [6:0]       m_chip_q, m_chip_d;
  logic [2:0]       status_q, status_d;
  logic             m_wr_q, m_wr_d, m_rd_q, m_rd_d;
  logic [31:0]      cnt_q, cnt_d;
  logic             found, timeout;
  logic [6:0]       chip_a [N_REQ];
  logic [7:0]       reg_a  [N_REQ];
  logic [7:0]       wd_a   [N_REQ];
  int               j;
  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign chip_a[g] = bus.req_chip_addr[7*g +: 7];
    assign reg_a[g]  = bus.req_reg_addr[8*g +: 8];
    assign wd_a[g]   = bus.req_wdata[8*g +: 8];
  end
  assign timeout = TIMEOUT_CYCLES != 0 && cnt_q >= TIMEOUT_CYCLES;
  // search upward from ptr with wrap; scanning offsets high to low lets the nearest request win
  always_comb begin
    sel = ptr_q;
    found = 1'b0;
    j = 0;
    jj = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = int'(ptr_q) + i;
      if (j >= N_REQ) j = j - N_REQ;
      jj = PW'(j);
      if (bus.req[jj]) begin
        sel = jj;
        found = 1'b1;
      end
    end
    for (int i = 0; i < N_REQ; i++) sel_oh[i] = PW'(i) == sel;
  end
  // next-state and output registers; done in the first WAIT cycle is a stale level and is ignored
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    owner_d = owner_q;
    grant_d = grant_q;
    ack_d = '0;
    rdata_d = rdata_q;
    status_d = status_q;
    m_chip_d = m_chip_q;
    m_reg_d = m_reg_q;
    m_data_d = m_data_q;
    m_wr_d = 1'b0;
    m_rd_d = 1'b0;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (found && !bus.m_busy) begin
        owner_d = sel;
        grant_d = sel_oh;
        state_d = ISSUE;
      end
      ISSUE: begin
        m_chip_d = chip_a[owner_q];
        m_reg_d = reg_a[owner_q];
        m_data_d = wd_a[owner_q];
        m_rd_d = bus.req_rnw[owner_q];
        m_wr_d = !bus.req_rnw[owner_q];
        cnt_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = &cnt_q ? cnt_q : cnt_q + 32'd1;
        if (cnt_q != 0 && bus.m_done) begin
          status_d = bus.m_status;
          rdata_d = bus.m_data_out;
          ack_d = grant_q;
          state_d = ACK;
        end else if (timeout) begin
          status_d = 3'b111;
          ack_d = grant_q;
          state_d = ACK;
        end
      end
      ACK: begin
        grant_d = '0;
        ptr_d = owner_q == PW'(N_REQ - 1) ? '0 : owner_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and output flops, cleared immediately by the shared low-active reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q <= '0;
      owner_q <= '0;
      grant_q <= '0;
      ack_q <= '0;
      rdata_q <= '0;
      status_q <= '0;
      m_chip_q <= '0;
      m_reg_q <= '0;
      m_data_q <= '0;
      m_wr_q <= 1'b0;
      m_rd_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      ack_q <= ack_d;
      rdata_q <= rdata_d;
      status_q <= status_d;
      m_chip_q <= m_chip_d;
      m_reg_q <= m_reg_d;
      m_data_q <= m_data_d;
      m_wr_q <= m_wr_d;
      m_rd_q <= m_rd_d;
      cnt_q <= cnt_d;
    end
  end
  assign bus.grant = grant_q;
  assign bus.ack = ack_q;
  assign bus.rdata = rdata_q;
  assign bus.status = status_q;
  assign bus.m_chip_addr = m_chip_q;
  assign bus.m_reg_addr = m_reg_q;
  assign bus.m_data_in = m_data_q;
  assign bus.m_write_en = m_wr_q;
  assign bus.m_read_en = m_rd_q;
endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// tb_i2c_bus_arbiter: table-driven and sequence checks of the arbiter against an i2c_master model
module tb_i2c_bus_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  i2c_bus_arbiter_if #(.N_REQ(2)) bus ();
  i2c_bus_arbiter #(.N_REQ(2), .TIMEOUT_CYCLES(100)) dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {
    int         id;
    logic       rnw;
    logic [6:0] chip;
    logic [7:0] rg;
    logic [7:0] wd;
    int         dly;
    logic [7:0] exp_rd;
    logic [2:0] exp_st;
  } vec_t;
  vec_t       sb[$];
  vec_t       tbl[6];
  int         checks = 0, failures = 0, cyc = 0, en_cyc = 0, ack_lat = 0;
  int         mdl_dly = 1;
  logic       done_pulse, done_force, mdl_mute, ack_seen;
  logic [7:0] held = 8'h00;
  assign bus.m_done = done_pulse | done_force;
  function automatic logic [7:0] rsp_rd(input logic [7:0] r);
    return r ^ 8'h18;
  endfunction
  function automatic logic [2:0] rsp_st(input logic [7:0] r);
    return {1'b0, r[1:0]};
  endfunction
  // master model: mdl_dly cycles after a start pulse, one-cycle done with data derived from reg_addr
  initial begin
    done_pulse = 1'b0;
    bus.m_status = '0;
    bus.m_data_out = '0;
    forever begin
      @(negedge clk);
      if ((bus.m_write_en || bus.m_read_en) && !mdl_mute) begin
        repeat (mdl_dly) @(negedge clk);
        bus.m_status = rsp_st(bus.m_reg_addr);
        bus.m_data_out = rsp_rd(bus.m_reg_addr);
        done_pulse = 1'b1;
        @(negedge clk);
        done_pulse = 1'b0;
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic mon();
    vec_t e;
    cyc++;
    chk("grant_onehot0", 32'($onehot0(bus.grant)), 1);
    if (bus.m_write_en || bus.m_read_en) begin
      en_cyc = cyc;
      chk("en_exclusive", 32'(bus.m_write_en & bus.m_read_en), 0);
      chk("issue_pending", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        chk("issue_grant", 32'(bus.grant), 1 << sb[0].id);
        chk("issue_read", 32'(bus.m_read_en), 32'(sb[0].rnw));
        chk("issue_chip", 32'(bus.m_chip_addr), 32'(sb[0].chip));
        chk("issue_reg", 32'(bus.m_reg_addr), 32'(sb[0].rg));
        if (!sb[0].rnw) chk("issue_wdata", 32'(bus.m_data_in), 32'(sb[0].wd));
      end
    end
    if (bus.ack != 0) begin
      ack_seen = 1'b1;
      ack_lat = cyc - en_cyc;
      chk("ack_pending", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("ack_owner", 32'(bus.ack), 1 << e.id);
        chk("ack_grant", 32'(bus.grant), 1 << e.id);
        chk("ack_rdata", 32'(bus.rdata), 32'(e.exp_rd));
        chk("ack_status", 32'(bus.status), 32'(e.exp_st));
        held = e.exp_rd;
      end
    end
  endtask
  task automatic step();
    @(negedge clk);
    mon();
  endtask
  task automatic run_until_ack(input int budget);
    ack_seen = 1'b0;
    for (int n = 0; n < budget && !ack_seen; n++) step();
    chk("ack_arrived", 32'(ack_seen), 1);
  endtask
  task automatic set_req(input vec_t v);
    bus.req_rnw[v.id] = v.rnw;
    bus.req_chip_addr[7*v.id +: 7] = v.chip;
    bus.req_reg_addr[8*v.id +: 8] = v.rg;
    bus.req_wdata[8*v.id +: 8] = v.wd;
    bus.req[v.id] = 1'b1;
  endtask
  task automatic chk_zero(input string name);
    chk({name, "_grant"}, 32'(bus.grant), 0);
    chk({name, "_ack"}, 32'(bus.ack), 0);
    chk({name, "_rdata"}, 32'(bus.rdata), 0);
    chk({name, "_status"}, 32'(bus.status), 0);
    chk({name, "_chip"}, 32'(bus.m_chip_addr), 0);
    chk({name, "_reg"}, 32'(bus.m_reg_addr), 0);
    chk({name, "_wdata"}, 32'(bus.m_data_in), 0);
    chk({name, "_wr"}, 32'(bus.m_write_en), 0);
    chk({name, "_rd"}, 32'(bus.m_read_en), 0);
  endtask
  task automatic run_row(input vec_t v);
    mdl_dly = v.dly;
    set_req(v);
    sb.push_back(v);
    step();
    chk("grant_latency", 32'(bus.grant), 1 << v.id);
    run_until_ack(50);
    bus.req[v.id] = 1'b0;
    chk("issue_to_ack", ack_lat, v.dly + 1);
    step();
    chk("grant_clear", 32'(bus.grant), 0);
    chk("rdata_held", 32'(bus.rdata), 32'(v.exp_rd));
    chk("status_held", 32'(bus.status), 32'(v.exp_st));
  endtask
  initial begin
    vec_t v, w, a, b;
    bus.req = '0;
    bus.req_rnw = '0;
    bus.req_chip_addr = '0;
    bus.req_reg_addr = '0;
    bus.req_wdata = '0;
    bus.m_busy = 1'b0;
    done_force = 1'b0;
    mdl_mute = 1'b0;
    tbl[0] = '{0, 1'b0, 7'h39, 8'h41, 8'h00, 2, 8'h59, 3'd1};
    tbl[1] = '{1, 1'b1, 7'h50, 8'h42, 8'h00, 1, 8'h5A, 3'd2};
    tbl[2] = '{0, 1'b1, 7'h21, 8'h00, 8'h00, 3, 8'h18, 3'd0};
    tbl[3] = '{1, 1'b0, 7'h7F, 8'hFF, 8'hA5, 4, 8'hE7, 3'd3};
    tbl[4] = '{0, 1'b0, 7'h00, 8'h83, 8'h3C, 1, 8'h9B, 3'd3};
    tbl[5] = '{1, 1'b1, 7'h48, 8'h10, 8'h00, 2, 8'h08, 3'd0};
    repeat (3) step();
    chk_zero("reset");
    reset = 1'b1;
    step();
    for (int i = 0; i < 6; i++) run_row(tbl[i]);
    v = '{0, 1'b0, 7'h2A, 8'h0E, 8'h99, 3, 8'h16, 3'd2};
    bus.m_busy = 1'b1;
    done_force = 1'b1;
    mdl_dly = 3;
    set_req(v);
    sb.push_back(v);
    repeat (3) begin
      step();
      chk("busy_no_grant", 32'(bus.grant), 0);
    end
    bus.m_busy = 1'b0;
    step();
    chk("busy_release_grant", 32'(bus.grant), 1);
    step();
    chk("stale_start", 32'(bus.m_write_en), 1);
    step();
    done_force = 1'b0;
    chk("stale_ignored", 32'(bus.ack), 0);
    run_until_ack(50);
    bus.req[0] = 1'b0;
    chk("stale_issue_to_ack", ack_lat, 4);
    step();
    mdl_mute = 1'b1;
    v = '{0, 1'b0, 7'h3A, 8'h55, 8'h77, 1, held, 3'b111};
    set_req(v);
    sb.push_back(v);
    step();
    chk("to_grant", 32'(bus.grant), 1);
    w = '{1, 1'b1, 7'h12, 8'h34, 8'h00, 2, 8'h2C, 3'd0};
    set_req(w);
    sb.push_back(w);
    mdl_dly = 2;
    run_until_ack(150);
    chk("to_latency", 32'(ack_lat >= 99 && ack_lat <= 102), 1);
    bus.req[0] = 1'b0;
    mdl_mute = 1'b0;
    step();
    chk("to_gap", 32'(bus.grant), 0);
    step();
    chk("to_next_grant", 32'(bus.grant), 2);
    run_until_ack(50);
    bus.req[1] = 1'b0;
    chk("to_next_issue_to_ack", ack_lat, 3);
    step();
    run_row(tbl[0]);
    mdl_mute = 1'b1;
    v = '{1, 1'b1, 7'h11, 8'h22, 8'h00, 1, 8'h00, 3'd0};
    set_req(v);
    sb.push_back(v);
    step();
    chk("rw_grant", 32'(bus.grant), 2);
    repeat (3) step();
    reset = 1'b0;
    #1;
    chk_zero("rw");
    sb.delete();
    a = '{0, 1'b0, 7'h05, 8'h61, 8'hC3, 1, 8'h79, 3'd1};
    b = '{1, 1'b1, 7'h11, 8'h22, 8'h00, 1, 8'h3A, 3'd2};
    set_req(a);
    set_req(b);
    repeat (3) begin
      step();
      chk("rw_no_ack", 32'(bus.ack), 0);
    end
    mdl_mute = 1'b0;
    mdl_dly = 1;
    reset = 1'b1;
    sb.push_back(a);
    sb.push_back(b);
    sb.push_back(a);
    sb.push_back(b);
    step();
    chk("rw_ptr0_grant", 32'(bus.grant), 1);
    for (int k = 0; k < 4; k++) begin
      run_until_ack(50);
      if (k == 3) bus.req = '0;
      step();
      chk("rr_gap", 32'(bus.grant), 0);
      if (k < 3) begin
        step();
        chk("rr_next", 32'(bus.grant), (k % 2 == 0) ? 2 : 1);
      end
    end
    repeat (3) begin
      step();
      chk("final_idle", 32'(bus.grant), 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
